// File: rtl/cordic_hyp_addr_gen.sv
// Front-end sequencer for the hyperbolic CORDIC pipeline: buffers signed arguments,
// reduces each one to sign/magnitude and issues ROM reads aligned with the ROM output.
module cordic_hyp_addr_gen #(
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [15:0]              in_data,
    input  logic                     run,
    input  logic                     flush,
    output logic                     rom_en,
    output logic [8:0]               rom_addr,
    output logic                     wen,
    output logic [2:0]               index_qua,
    output logic [6:0]               index_cor,
    output logic [5:0]               residual,
    output logic [$clog2(DEPTH):0]   fifo_level,
    output logic [15:0]              issue_cnt
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0]   FULL_LEVEL = (AW+1)'(DEPTH);
    localparam logic [AW:0]   LEVEL_ONE  = (AW+1)'(1);
    localparam logic [AW-1:0] PTR_ONE    = AW'(1);

    logic [15:0]   r_mem [DEPTH];
    logic [AW-1:0] r_wrPtr;
    logic [AW-1:0] r_rdPtr;
    logic [AW:0]   r_level;
    logic          r_inReady;
    logic [15:0]   r_issueCnt;

    logic          r_romEn;
    logic [8:0]    r_romAddr;
    logic [2:0]    r_quaS1;
    logic [6:0]    r_corS1;
    logic [5:0]    r_resS1;

    logic          r_wen;
    logic [2:0]    r_qua;
    logic [6:0]    r_cor;
    logic [5:0]    r_res;

    logic          w_push;
    logic          w_pop;
    logic [AW:0]   w_levelNext;
    logic [15:0]   w_head;
    logic          w_sign;
    logic [15:0]   w_neg;
    logic [15:0]   w_mag;

    assign w_push = in_valid && r_inReady && !flush;
    assign w_pop  = run && (r_level != '0) && !flush;

    always_comb begin
        w_levelNext = r_level;
        if (flush) begin
            w_levelNext = '0;
        end else if (w_push && !w_pop) begin
            w_levelNext = r_level + LEVEL_ONE;
        end else if (w_pop && !w_push) begin
            w_levelNext = r_level - LEVEL_ONE;
        end
    end

    // Only 0x8000 keeps bit 15 set after negation; clamp it to the largest magnitude.
    assign w_head = r_mem[r_rdPtr];
    assign w_sign = w_head[15];
    assign w_neg  = -w_head;
    assign w_mag  = !w_sign ? w_head : (w_neg[15] ? 16'h7FFF : w_neg);

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wrPtr] <= in_data;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_wrPtr    <= '0;
            r_rdPtr    <= '0;
            r_level    <= '0;
            r_inReady  <= 1'b1;
            r_issueCnt <= '0;
        end else begin
            r_level   <= w_levelNext;
            r_inReady <= (w_levelNext != FULL_LEVEL);
            if (flush) begin
                r_wrPtr <= '0;
                r_rdPtr <= '0;
            end else begin
                if (w_push) begin
                    r_wrPtr <= r_wrPtr + PTR_ONE;
                end
                if (w_pop) begin
                    r_rdPtr    <= r_rdPtr + PTR_ONE;
                    r_issueCnt <= r_issueCnt + 16'd1;
                end
            end
        end
    end

    // S1 issues the ROM read; S2 delays the side information to line up with Q.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_romEn   <= 1'b0;
            r_romAddr <= '0;
            r_quaS1   <= '0;
            r_corS1   <= '0;
            r_resS1   <= '0;
            r_wen     <= 1'b0;
            r_qua     <= '0;
            r_cor     <= '0;
            r_res     <= '0;
        end else begin
            r_romEn <= w_pop;
            if (w_pop) begin
                r_romAddr <= {w_mag[14:13], w_mag[12:6]};
                r_quaS1   <= {w_sign, w_mag[14:13]};
                r_corS1   <= w_mag[12:6];
                r_resS1   <= w_mag[5:0];
            end
            r_wen <= r_romEn;
            if (r_romEn) begin
                r_qua <= r_quaS1;
                r_cor <= r_corS1;
                r_res <= r_resS1;
            end
        end
    end

    assign in_ready   = r_inReady;
    assign rom_en     = r_romEn;
    assign rom_addr   = r_romAddr;
    assign wen        = r_wen;
    assign index_qua  = r_qua;
    assign index_cor  = r_cor;
    assign residual   = r_res;
    assign fifo_level = r_level;
    assign issue_cnt  = r_issueCnt;

endmodule
